sad_ctrl: RTL and testbench
===========================

Name: sad_ctrl

Overview:
- Control FSM and address generator that sequences the 128-block SAD datapath.
- Streams 256 pixel pairs per block from operand SRAMs A/B.
- Issues clear/accumulate strobes to the SAD accumulator.
- Writes each block's 32-bit result into result SRAM C at address = block index; raises Done when all ITR blocks are stored.
- Replaces the controller portion of the SAD top; sits between Go/Done and the three Sram instances.

Parameters:
A_WIDTH, 15, operand SRAM address width; must equal log2(ITR)+BLK_LOG2
CA_WIDTH, 7, result SRAM address width = log2(ITR)
ITR, 128, number of blocks
BLK_LOG2, 8, log2 pixels per block (256)

Ports:
Clk  in  1  system clock, rising edge
Rst  in  1  reset, asynchronous, active-low (0 = reset)
Go  in  1  start request, sampled on Clk in IDLE/DONE
Done  out  1  all blocks written; level, held until next accepted Go or reset
Busy  out  1  high in CLR/RD/DRN/WR
A_Addr  out  A_WIDTH  operand A address = {blk,pix}
B_Addr  out  A_WIDTH  operand B address, identical to A_Addr
C_Addr  out  CA_WIDTH  result address = blk
I_RW  out  1  operand SRAM R/W (0 = read; always 0)
I_En  out  1  operand SRAM enable
O_RW  out  1  result SRAM R/W (1 = write)
O_En  out  1  result SRAM enable
Sum_Clr  out  1  clear accumulator
Sum_Acc  out  1  accumulate |A_Data-B_Data| this cycle (SRAM read latency 1 cycle)

Behaviour:
- Reset (Rst=0, async): state IDLE, blk=0, pix=0, every output 0.
- IDLE: all strobes 0. Go=1 -> CLR.
- CLR: Sum_Clr=1, pix<=0 -> RD.
- RD:
  - I_En=1, I_RW=0, A_Addr=B_Addr={blk,pix}.
  - Sum_Acc=1 iff pix!=0, which accumulates the data returned for pix-1.
  - pix==2^BLK_LOG2-1 -> DRN; otherwise pix++.
- DRN: I_En=0, Sum_Acc=1 (last pixel) -> WR.
- WR:
  - O_En=1, O_RW=1, C_Addr=blk; the datapath's registered SAD_Out is stable this cycle.
  - blk==ITR-1 -> DONE, blk<=0; otherwise blk++ -> CLR.
- DONE: Done=1. Go=1 -> CLR (Done drops the same edge).
- Timing: 259 cycles per block (1 CLR + 256 RD + 1 DRN + 1 WR). Go accepted at edge 0 -> CLR at cycle 1 -> Done at cycle 1+ITR*259 (33153 at default).
- Exactly 2^BLK_LOG2 Sum_Acc pulses and 1 Sum_Clr per block.
- Addresses: pix wraps 255->0 only via CLR. A_Addr/B_Addr/C_Addr are 0 outside RD/WR.
- Go while Busy is ignored. Go held continuously causes an immediate restart from DONE.
- Reset mid-operation aborts immediately. Already-written C entries are untouched; the restart begins at block 0.
- All outputs are decoded from registered state/counters (Moore); no combinational path from Go to outputs.

Optional Feature:
- Macro SAD_ABORT_EN.
- Defined:
  - Adds input port Abort (1 bit).
  - Abort=1 in CLR/RD/DRN -> IDLE next edge, blk/pix <= 0, no write of the partial block, Done stays 0.
  - Abort in WR: that cycle's write completes, then IDLE.
  - Abort is ignored in IDLE/DONE; Go wins when both are high there.
- Undefined: no Abort port; behaviour as above.

Decomposition:
- Package sad_pkg: A_WIDTH/D_WIDTH/CA_WIDTH/ITR/BLK_LOG2 constants, FSM state encoding (IDLE, CLR, RD, DRN, WR, DONE), RW encodings (RD_OP=0, WR_OP=1).
- One sub-module: sad_addr_cnt, holding the blk/pix counters with clr/inc/wrap flags. The FSM stays in sad_ctrl.

Test Plan:
- Default run: Rst low then high, Go pulse at edge 0 -> Sum_Clr at cycle 1, A_Addr=0x0000 with I_En at cycle 2, Done=1 at cycle 33153, 128 writes with C_Addr 0..127 in order.
- Block 5 boundary: cycle 1552 -> A_Addr=B_Addr=0x05FF, Sum_Acc=1; cycle 1553 DRN with I_En=0, Sum_Acc=1; cycle 1554 O_En=1, C_Addr=5.
- Pulse counting: per block 256 Sum_Acc, 1 Sum_Clr, 1 O_En. Go pulsed at cycle 3000 -> ignored, total writes still 128.
- Reset mid-block: Rst=0 at cycle 1000 -> all outputs 0 immediately, Busy=0. After release, Go -> first address 0x0000 again.
- Integrated with SAD datapath, Sram_Operand A/B loaded from MemA/MemB, and Sram_Result: all 128 C entries match sw_result.
- SAD_ABORT_EN: Abort at cycle 600 (block 2 RD) -> IDLE at 601, only C[0], C[1] written, Done never asserted. Abort in WR of block 3 -> C[3] written, then IDLE.

Source files
------------

// File: rtl/sad_pkg.sv
// sad_pkg
// Shared constants for the SAD controller slice: datapath geometry, FSM state
// encoding and SRAM read/write encodings.
// Ports: none (package).
package sad_pkg;

    localparam int A_WIDTH  = 15;   // operand SRAM address width = log2(ITR) + BLK_LOG2
    localparam int D_WIDTH  = 8;    // operand pixel width
    localparam int CA_WIDTH = 7;    // result SRAM address width = log2(ITR)
    localparam int ITR      = 128;  // number of blocks
    localparam int BLK_LOG2 = 8;    // log2 pixels per block

    localparam int STATE_W = 3;

    // FSM state encoding
    localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
    localparam logic [STATE_W-1:0] ST_CLR  = 3'd1;
    localparam logic [STATE_W-1:0] ST_RD   = 3'd2;
    localparam logic [STATE_W-1:0] ST_DRN  = 3'd3;
    localparam logic [STATE_W-1:0] ST_WR   = 3'd4;
    localparam logic [STATE_W-1:0] ST_DONE = 3'd5;

    // SRAM R/W encodings
    localparam logic RD_OP = 1'b0;
    localparam logic WR_OP = 1'b1;

endpackage

// File: rtl/sad_addr_cnt.sv
// sad_addr_cnt
// Block and pixel counters that form the operand/result addresses of the SAD
// controller. Clear has priority over increment on each counter.
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   pix_clr, pix_inc   pixel counter clear / increment
//   blk_clr, blk_inc   block counter clear / increment
//   blk, pix           current counter values
//   pix_wrap           pixel counter is at its last pixel of the block
//   blk_wrap           block counter is at the last block
module sad_addr_cnt
    import sad_pkg::*;
#(
    parameter int BLK_W = CA_WIDTH,
    parameter int PIX_W = BLK_LOG2,
    parameter int N_BLK = ITR
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_clr,
    input  logic             pix_inc,
    input  logic             blk_clr,
    input  logic             blk_inc,
    output logic [BLK_W-1:0] blk,
    output logic [PIX_W-1:0] pix,
    output logic             pix_wrap,
    output logic             blk_wrap
);

    logic [BLK_W-1:0] blk_d, blk_q;
    logic [PIX_W-1:0] pix_d, pix_q;

    always_comb begin
        pix_d = pix_q;
        if (pix_clr) begin
            pix_d = '0;
        end else if (pix_inc) begin
            pix_d = pix_q + PIX_W'(1);
        end

        blk_d = blk_q;
        if (blk_clr) begin
            blk_d = '0;
        end else if (blk_inc) begin
            blk_d = blk_q + BLK_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_q <= '0;
            blk_q <= '0;
        end else begin
            pix_q <= pix_d;
            blk_q <= blk_d;
        end
    end

    assign blk      = blk_q;
    assign pix      = pix_q;
    assign pix_wrap = (pix_q == {PIX_W{1'b1}});
    assign blk_wrap = (blk_q == BLK_W'(N_BLK - 1));

endmodule

// File: rtl/sad_ctrl.sv
// sad_ctrl
// Control FSM and address generator for the 128-block SAD datapath. For every
// block it clears the accumulator, streams 2^BLK_LOG2 pixel pairs from operand
// SRAMs A/B, drains the last returned pixel, then writes the registered SAD
// result into result SRAM C at the block index. Done is raised once every
// block has been stored.
// Optional feature: define SAD_ABORT_EN to add the Abort input, which returns
// the controller to IDLE without writing the partial block.
// Ports:
//   Clk, Rst          clock (rising edge), asynchronous active-low reset
//   Go                start request, accepted in IDLE/DONE
//   Abort             (SAD_ABORT_EN only) cancel the current run
//   Done, Busy        status
//   A_Addr, B_Addr    operand addresses {blk,pix}, valid in RD only
//   C_Addr            result address = blk, valid in WR only
//   I_RW, I_En        operand SRAM controls (always reading)
//   O_RW, O_En        result SRAM controls
//   Sum_Clr, Sum_Acc  accumulator strobes
// All outputs are decoded from registered state and counters only.
module sad_ctrl #(
    parameter int A_WIDTH  = sad_pkg::A_WIDTH,
    parameter int CA_WIDTH = sad_pkg::CA_WIDTH,
    parameter int ITR      = sad_pkg::ITR,
    parameter int BLK_LOG2 = sad_pkg::BLK_LOG2
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                Go,
`ifdef SAD_ABORT_EN
    input  logic                Abort,
`endif
    output logic                Done,
    output logic                Busy,
    output logic [A_WIDTH-1:0]  A_Addr,
    output logic [A_WIDTH-1:0]  B_Addr,
    output logic [CA_WIDTH-1:0] C_Addr,
    output logic                I_RW,
    output logic                I_En,
    output logic                O_RW,
    output logic                O_En,
    output logic                Sum_Clr,
    output logic                Sum_Acc
);

    import sad_pkg::*;

    logic [STATE_W-1:0]  state_d, state_q;
    logic                pix_clr, pix_inc, blk_clr, blk_inc;
    logic                pix_wrap, blk_wrap;
    logic [CA_WIDTH-1:0] blk;
    logic [BLK_LOG2-1:0] pix;

    sad_addr_cnt #(
        .BLK_W (CA_WIDTH),
        .PIX_W (BLK_LOG2),
        .N_BLK (ITR)
    ) u_addr_cnt (
        .clk      (Clk),
        .rst_n    (Rst),
        .pix_clr  (pix_clr),
        .pix_inc  (pix_inc),
        .blk_clr  (blk_clr),
        .blk_inc  (blk_inc),
        .blk      (blk),
        .pix      (pix),
        .pix_wrap (pix_wrap),
        .blk_wrap (blk_wrap)
    );

    // Next-state and counter control. The pixel counter only returns to zero
    // through CLR, so it sits at its last value through DRN/WR; the addresses
    // are masked outside RD/WR so this is never visible.
    always_comb begin
        state_d = state_q;
        pix_clr = 1'b0;
        pix_inc = 1'b0;
        blk_clr = 1'b0;
        blk_inc = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Go) begin
                    state_d = ST_CLR;
                end
            end
            ST_CLR: begin
                pix_clr = 1'b1;
                state_d = ST_RD;
            end
            ST_RD: begin
                if (pix_wrap) begin
                    state_d = ST_DRN;
                end else begin
                    pix_inc = 1'b1;
                end
            end
            ST_DRN: begin
                state_d = ST_WR;
            end
            ST_WR: begin
                if (blk_wrap) begin
                    blk_clr = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    blk_inc = 1'b1;
                    state_d = ST_CLR;
                end
            end
            ST_DONE: begin
                if (Go) begin
                    state_d = ST_CLR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef SAD_ABORT_EN
        // Abort overrides everything while busy. In WR the write strobe is
        // already on the bus this cycle, so that block still lands in C.
        if (Abort && (state_q == ST_CLR || state_q == ST_RD ||
                      state_q == ST_DRN || state_q == ST_WR)) begin
            state_d = ST_IDLE;
            pix_clr = 1'b1;
            pix_inc = 1'b0;
            blk_clr = 1'b1;
            blk_inc = 1'b0;
        end
`endif
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Moore output decode. Accumulation lags the read address by one cycle
    // (SRAM read latency), so RD at pix 0 has nothing to accumulate and DRN
    // picks up the final pixel.
    always_comb begin
        Done    = (state_q == ST_DONE);
        Busy    = (state_q == ST_CLR) || (state_q == ST_RD) ||
                  (state_q == ST_DRN) || (state_q == ST_WR);
        Sum_Clr = (state_q == ST_CLR);
        Sum_Acc = ((state_q == ST_RD) && (pix != '0)) || (state_q == ST_DRN);
        I_RW    = RD_OP;
        I_En    = (state_q == ST_RD);
        O_En    = (state_q == ST_WR);
        O_RW    = (state_q == ST_WR) ? WR_OP : RD_OP;
        A_Addr  = (state_q == ST_RD) ? A_WIDTH'({blk, pix}) : '0;
        B_Addr  = A_Addr;
        C_Addr  = (state_q == ST_WR) ? blk : '0;
    end

endmodule

// File: tb/tb_sad_ctrl.sv
// tb_sad_ctrl
// Self-checking bench for sad_ctrl. A cycle-count model (run position ->
// block/offset arithmetic) predicts every output each cycle; pulse counts,
// write order and fixed cycle points are checked on top. Random Go pulses
// are injected while busy. Abort scenarios run when SAD_ABORT_EN is defined.
module tb_sad_ctrl;

    import sad_pkg::*;

    localparam int PIX     = 1 << BLK_LOG2;
    localparam int BLK_CYC = PIX + 3;
    localparam int RUN_CYC = ITR * BLK_CYC;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic                Clk = 1'b0;
    logic                Rst = 1'b0;
    logic                Go  = 1'b0;
`ifdef SAD_ABORT_EN
    logic                Abort = 1'b0;
`endif
    logic                Done, Busy, I_RW, I_En, O_RW, O_En, Sum_Clr, Sum_Acc;
    logic [A_WIDTH-1:0]  A_Addr, B_Addr;
    logic [CA_WIDTH-1:0] C_Addr;

    int assertCount = 0;
    int failCount   = 0;

    // Reference model state: mode plus position inside the current run.
    int mode   = M_IDLE;
    int tRun   = 0;
    int runCyc = 0;

    // Observed statistics
    int accInBlk = 0;
    int clrInBlk = 0;
    int writes[$];

    sad_ctrl dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .Go      (Go),
`ifdef SAD_ABORT_EN
        .Abort   (Abort),
`endif
        .Done    (Done),
        .Busy    (Busy),
        .A_Addr  (A_Addr),
        .B_Addr  (B_Addr),
        .C_Addr  (C_Addr),
        .I_RW    (I_RW),
        .I_En    (I_En),
        .O_RW    (O_RW),
        .O_En    (O_En),
        .Sum_Clr (Sum_Clr),
        .Sum_Acc (Sum_Acc)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (runCyc %0d)", tag, obs, exp, runCyc);
        end
    endtask

    function automatic logic [63:0] obsVec();
        logic [63:0] v;
        v = '0;
        v[14:0]  = A_Addr;
        v[29:15] = B_Addr;
        v[36:30] = C_Addr;
        v[37]    = Sum_Acc;
        v[38]    = Sum_Clr;
        v[39]    = O_En;
        v[40]    = O_RW;
        v[41]    = I_En;
        v[42]    = I_RW;
        v[43]    = Busy;
        v[44]    = Done;
        return v;
    endfunction

    // Expected outputs from the run position: each block is one clear cycle,
    // PIX read cycles, one drain cycle and one write cycle.
    function automatic logic [63:0] modelVec();
        logic [63:0] v;
        int b, o, a;
        v = '0;
        if (mode == M_DONE) begin
            v[44] = 1'b1;
        end else if (mode == M_RUN) begin
            b = (tRun - 1) / BLK_CYC;
            o = (tRun - 1) % BLK_CYC;
            v[43] = 1'b1;
            if (o == 0) begin
                v[38] = 1'b1;
            end else if (o <= PIX) begin
                a = b * PIX + (o - 1);
                v[14:0]  = 15'(a);
                v[29:15] = 15'(a);
                v[41]    = 1'b1;
                v[37]    = (o > 1);
            end else if (o == PIX + 1) begin
                v[37] = 1'b1;
            end else begin
                v[39]    = 1'b1;
                v[40]    = 1'b1;
                v[36:30] = 7'(b);
            end
        end
        return v;
    endfunction

    task automatic clearStats();
        accInBlk = 0;
        clrInBlk = 0;
    endtask

    task automatic applyStimulus(input logic goVal);
        Go = goVal;
    endtask

    // One clock: sample inputs at the edge, advance the model, compare #1 later.
    task automatic stepCycle();
        logic goS, abS;
        @(posedge Clk);
        goS = Go;
        abS = 1'b0;
`ifdef SAD_ABORT_EN
        abS = Abort;
`endif
        #1;
        if (!Rst) begin
            mode = M_IDLE;
            runCyc++;
        end else if (mode != M_RUN && goS) begin
            mode   = M_RUN;
            tRun   = 1;
            runCyc = 1;
        end else if (mode == M_RUN && abS) begin
            mode = M_IDLE;
            runCyc++;
        end else begin
            if (mode == M_RUN) begin
                tRun++;
                if (tRun > RUN_CYC) mode = M_DONE;
            end
            runCyc++;
        end

        checkOutput("outputs", obsVec(), modelVec());

        if (Sum_Clr) clrInBlk++;
        if (Sum_Acc) accInBlk++;
        if (O_En) begin
            writes.push_back(int'(C_Addr));
            checkOutput("accPerBlk", 64'(accInBlk), 64'(PIX));
            checkOutput("clrPerBlk", 64'(clrInBlk), 64'd1);
            clearStats();
        end

        if (mode == M_RUN && runCyc == 1)    checkOutput("clrAt1", 64'(Sum_Clr), 64'd1);
        if (mode == M_RUN && runCyc == 2)    checkOutput("firstAddr", 64'({I_En, A_Addr}), 64'({1'b1, 15'h0000}));
        if (mode == M_RUN && runCyc == 1552) begin
            checkOutput("blk5LastA", 64'(A_Addr), 64'h05FF);
            checkOutput("blk5LastB", 64'(B_Addr), 64'h05FF);
            checkOutput("blk5LastAcc", 64'(Sum_Acc), 64'd1);
        end
        if (mode == M_RUN && runCyc == 1553) checkOutput("blk5Drn", 64'({I_En, Sum_Acc}), 64'b01);
        if (mode == M_RUN && runCyc == 1554) checkOutput("blk5Wr", 64'({O_En, C_Addr}), 64'({1'b1, 7'd5}));
        if (mode == M_RUN && runCyc == 33152) checkOutput("doneLowBefore", 64'(Done), 64'd0);
        if (mode == M_DONE && runCyc == 33153) checkOutput("doneAt33153", 64'(Done), 64'd1);
    endtask

    initial begin
        $display("[TB] sad_ctrl bench start");
        applyStimulus(1'b0);
        Rst = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        checkOutput("resetOuts", obsVec(), 64'd0);
        Rst = 1'b1;

        // Full run: Go accepted at edge 0, random Go pulses while busy.
        applyStimulus(1'b1);
        stepCycle();
        applyStimulus(1'b0);
        for (int k = 0; k < RUN_CYC + 2; k++) begin
            applyStimulus((runCyc == 3000) ||
                          (runCyc > 3 && runCyc < RUN_CYC - 10 && $urandom_range(0, 299) == 0));
            stepCycle();
        end
        applyStimulus(1'b0);
        checkOutput("wrCount", 64'(writes.size()), 64'(ITR));
        for (int i = 0; i < writes.size(); i++) begin
            checkOutput("wrOrder", 64'(writes[i]), 64'(i));
        end
        writes.delete();
        clearStats();

        // Go held in DONE restarts at once; further Go while busy is ignored.
        applyStimulus(1'b1);
        stepCycle();
        checkOutput("restartDoneDrop", 64'(Done), 64'd0);
        repeat (3) stepCycle();
        for (int k = 0; k < 996; k++) begin
            applyStimulus($urandom_range(0, 199) == 0);
            stepCycle();
        end
        applyStimulus(1'b0);

        // Asynchronous reset mid-block.
        #3;
        Rst = 1'b0;
        #1;
        checkOutput("rstAsyncOuts", obsVec(), 64'd0);
        checkOutput("rstBusy", 64'(Busy), 64'd0);
        mode = M_IDLE;
        clearStats();
        writes.delete();
        repeat (2) stepCycle();
        Rst = 1'b1;
        stepCycle();
        applyStimulus(1'b1);
        stepCycle();
        applyStimulus(1'b0);
        for (int k = 0; k < 599; k++) begin
            applyStimulus(runCyc > 3 && $urandom_range(0, 149) == 0);
            stepCycle();
        end
        applyStimulus(1'b0);
        checkOutput("wrAfterRst", 64'(writes.size()), 64'd2);

`ifdef SAD_ABORT_EN
        // Abort during block 2 read: no partial write, no Done.
        Abort = 1'b1;
        stepCycle();
        Abort = 1'b0;
        checkOutput("abortIdle", 64'(Busy), 64'd0);
        clearStats();
        repeat (20) stepCycle();
        checkOutput("abortWrCount", 64'(writes.size()), 64'd2);
        checkOutput("abortNoDone", 64'(Done), 64'd0);

        // Abort in block 3 write: that write lands, then idle.
        applyStimulus(1'b1);
        stepCycle();
        applyStimulus(1'b0);
        for (int k = 0; k < 1035; k++) stepCycle();
        Abort = 1'b1;
        stepCycle();
        Abort = 1'b0;
        clearStats();
        repeat (10) stepCycle();
        checkOutput("abortWrWrites", 64'(writes.size()), 64'd6);
        checkOutput("abortWrLast", 64'(writes[writes.size()-1]), 64'd3);
        checkOutput("abortWrIdle", 64'({Busy, Done}), 64'd0);
`else
        repeat (100) stepCycle();
        checkOutput("wrAfterRstLater", 64'(writes.size()), 64'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
